// File: rtl/ysyx_24090012_pkg.sv
// Shared constants for the RV32E multi-cycle controller: decoder op codes,
// sequencer states, error codes and reset defaults.
package ysyx_24090012_pkg;

  localparam logic [3:0] OP_ADDI    = 4'b0000;
  localparam logic [3:0] OP_SEQZ    = 4'b0001;
  localparam logic [3:0] OP_LUI     = 4'b0010;
  localparam logic [3:0] OP_ADD     = 4'b0011;
  localparam logic [3:0] OP_SUB     = 4'b0100;
  localparam logic [3:0] OP_AUIPC   = 4'b0101;
  localparam logic [3:0] OP_BEQ     = 4'b0110;
  localparam logic [3:0] OP_BNE     = 4'b0111;
  localparam logic [3:0] OP_LW      = 4'b1000;
  localparam logic [3:0] OP_SW      = 4'b1001;
  localparam logic [3:0] OP_JAL     = 4'b1010;
  localparam logic [3:0] OP_EBREAK  = 4'b1011;
  localparam logic [3:0] OP_JALR    = 4'b1100;
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FWAIT,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_MWAIT,
    S_WB,
    S_HALT,
    S_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

  function automatic logic is_bus_wait(input state_e s);
    return (s == S_FETCH) || (s == S_FWAIT) || (s == S_MEM) || (s == S_MWAIT);
  endfunction

endpackage

// File: rtl/ysyx_24090012_ctrl_timer.sv
// Bus-wait watchdog: cleared on state entry, counts cycles spent waiting,
// flags expiry on the TIMEOUT-th waiting cycle. TIMEOUT = 0 disables it.
module ysyx_24090012_ctrl_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // cnt_q is the number of waiting cycles already completed, so the current
  // cycle is number cnt_q + 1.
  always_comb begin
    expired = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT);
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (TIMEOUT != 0) && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_24090012_ctrl.sv
// Multi-cycle sequencer for the RV32E core: owns PC/IR, runs fetch and LSU
// handshakes, strobes rf_we. Define YSYX_24090012_CTRL_PERF_EN for perf counters.
module ysyx_24090012_ctrl
  import ysyx_24090012_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  output logic [31:0] inst,
  input  logic [3:0]  alu_op,
  input  logic [31:0] npc,
  output logic        mem_req_valid,
  output logic        mem_req_wen,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  output logic        rf_we,
  output logic        halt,
  output logic        err,
`ifdef YSYX_24090012_CTRL_PERF_EN
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt,
`endif
  output logic [1:0]  err_code
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        tmr_clr;
  logic        tmr_expired;

  ysyx_24090012_ctrl_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .inc    (is_bus_wait(state_q)),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    err_code_d = err_code_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (ifu_req_ready) begin
          state_d = S_FWAIT;
        end else if (tmr_expired) begin
          state_d    = S_ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_FWAIT: begin
        if (ifu_rsp_valid) begin
          inst_d  = ifu_rsp_data;
          state_d = S_DECODE;
        end else if (tmr_expired) begin
          state_d    = S_ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (alu_op == OP_ILLEGAL) begin
          state_d    = S_ERROR;
          err_code_d = ERR_ILLEGAL;
        end else if (alu_op == OP_EBREAK) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = ((alu_op == OP_LW) || (alu_op == OP_SW)) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_req_ready) begin
          state_d = S_MWAIT;
        end else if (tmr_expired) begin
          state_d    = S_ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_MWAIT: begin
        if (mem_rsp_valid) begin
          state_d = S_WB;
        end else if (tmr_expired) begin
          state_d    = S_ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_WB: begin
        pc_d    = npc;
        state_d = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase

    // Every state change clears the watchdog, so each wait state starts at 0.
    tmr_clr = (state_d != state_q);

    pc            = pc_q;
    inst          = inst_q;
    err_code      = err_code_q;
    ifu_req_valid = (state_q == S_FETCH);
    mem_req_valid = (state_q == S_MEM);
    mem_req_wen   = (state_q == S_MEM) && (alu_op == OP_SW);
    rf_we         = (state_q == S_WB) &&
                    !((alu_op == OP_BEQ) || (alu_op == OP_BNE) || (alu_op == OP_SW));
    halt          = (state_q == S_HALT);
    err           = (state_q == S_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      err_code_q <= err_code_d;
    end
  end

`ifdef YSYX_24090012_CTRL_PERF_EN
  logic [63:0] cycle_cnt_q, cycle_cnt_d;
  logic [63:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if ((state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR)) begin
      cycle_cnt_d = cycle_cnt_q + 64'd1;
    end
    if (state_q == S_WB) begin
      instret_cnt_d = instret_cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
